counter_share_arbiter: RTL and testbench
========================================

Name: counter_share_arbiter

Overview:
- Shares one SIZE-bit up/down/load counter between NREQ requesters.
- Each requester presents an operation: increment, decrement, load or read.
- A round-robin arbiter grants one requester per cycle, and the winner's operation is applied at the clock edge.
- Every completed operation returns a response carrying the post-operation count and the requester ID. Sits between the control agents and the shared count resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SIZE, 8, counter width in bits.
- INIT, 0, counter value loaded by reset.
- SATURATE, 0: 0 = inc/dec wrap modulo 2^SIZE; 1 = clamp at all-ones / zero.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request valid.
- op  input  2*NREQ  per-requester opcode; requester i uses bits [2i+1:2i]. 00 inc, 01 dec, 10 load, 11 read.
- wdata  input  NREQ*SIZE  per-requester load value; requester i uses bits [SIZE*i+SIZE-1:SIZE*i].
- gnt  output  NREQ  one-hot grant, combinational from req and the priority pointer.
- count  output  SIZE  current counter value, registered.
- rsp_valid  output  1  pulses high for 1 cycle after each completed operation.
- rsp_id  output  $clog2(NREQ)  index of the requester that completed.
- rsp_count  output  SIZE  counter value after the completed operation.
- ovf  output  1  sticky flag: an inc wrapped (SATURATE=0) or was clamped (SATURATE=1).
- unf  output  1  sticky flag: a dec wrapped or was clamped.
- clr_flags  input  1  synchronous clear of ovf/unf.

Behaviour:
- Reset (asynchronous, active-high; clock clk) sets:
  - count = INIT, priority pointer = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_count = 0.
  - ovf = unf = 0.
  - gnt = 0 while reset is asserted.
- Reset asserted mid-operation aborts any pending transfer; no response is generated for it.
- Arbitration (combinational):
  - Search req starting at the pointer and moving upward modulo NREQ; the first set bit wins.
  - gnt is one-hot or zero; gnt is zero when req is zero.
- Transfer:
  - Occurs at the rising edge when req[i] & gnt[i].
  - Exactly one transfer per cycle.
  - The pointer updates to (i+1) mod NREQ; with no transfer the pointer holds.
- Handshake rules:
  - A requester holds req, op and wdata stable until it samples gnt high at a clock edge.
  - It may deassert req or present a new operation the following cycle.
  - Back-to-back transfers from the same requester are allowed when no other req is set.
- Operations, latency 1 cycle (count and rsp_* are updated at the transfer edge):
  - inc: count+1. At all-ones, wraps to 0 (SATURATE=0) or holds all-ones (SATURATE=1); sets ovf in both cases.
  - dec: count-1. At 0, wraps to all-ones or holds 0; sets unf in both cases.
  - load: count = wdata slice of the winner; flags unchanged.
  - read: count unchanged; a response is still generated.
- Response: rsp_valid = 1 for exactly the cycle after the transfer, with rsp_id = i and rsp_count = new count. rsp_id and rsp_count hold their last values when rsp_valid = 0.
- Flags:
  - If clr_flags coincides with a transfer that sets a flag, the set wins.
  - Flags are otherwise sticky until clr_flags or reset.
- Requests whose req bit is low are ignored regardless of op and wdata contents.
- No starvation: a held request is granted within NREQ cycles.

Test Plan:
- Reset with INIT=5, then release -> count=5, rsp_valid=0, gnt=0. Then req[2]=1 op=inc -> gnt=0100; the next cycle shows count=6, rsp_valid=1, rsp_id=2, rsp_count=6.
- req=1111 held for 8 cycles, all op=inc, starting from count=0 -> grant order 0,1,2,3,0,1,2,3; count=8; each rsp_id matches the grant order.
- SATURATE=0, load 0xFF then inc -> count=0x00, ovf=1. Load 0x00 then dec -> count=0xFF, unf=1. Then clr_flags=1 -> ovf=unf=0.
- SATURATE=1, count=0xFF, inc -> count stays 0xFF, ovf=1. count=0, dec -> stays 0, unf=1.
- req[1] op=load wdata=0x3C simultaneously with req[3] op=read, pointer=0 -> requester 1 first (count=0x3C, rsp_id=1); requester 3 next cycle (rsp_count=0x3C, rsp_id=3).
- Assert reset asynchronously mid-stream with req=1111 -> count=INIT, pointer=0, and rsp_valid drops immediately. After release, requester 0 is granted first.

Source files
------------

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: one SIZE-bit up/down/load counter shared by NREQ
// requesters through a round-robin arbiter; one operation is applied per cycle.
module counter_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int SIZE     = 8,
    parameter int INIT     = 0,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        op,
    input  logic [NREQ*SIZE-1:0]     wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [SIZE-1:0]          count,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [SIZE-1:0]          rsp_count,
    output logic                     ovf,
    output logic                     unf,
    input  logic                     clr_flags
);

    localparam int              IDW      = $clog2(NREQ);
    localparam logic [SIZE-1:0] INIT_VAL = SIZE'(INIT);
    localparam logic [SIZE-1:0] ALL_ONES = '1;
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam bit              SAT      = (SATURATE != 0);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    // Handshake: req[i] is the valid and gnt[i] the ready of requester i. A
    // transfer happens at a rising edge where both are high; until then the
    // requester holds req[i], its op slice and its wdata slice stable.

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win_id;
    logic            win_found;
    logic            xfer;
    logic [1:0]      sel_op;
    logic [SIZE-1:0] sel_wdata;
    logic [SIZE-1:0] nxt_count;
    logic            set_ovf;
    logic            set_unf;

    // Walk upward from the pointer, wrapping at NREQ-1; first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
        end
    end

    assign xfer = win_found & ~reset;

    always_comb begin
        gnt = '0;
        if (xfer) begin
            gnt[win_id] = 1'b1;
        end
    end

    always_comb begin
        sel_op    = 2'b11;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_op    = op[2*i +: 2];
                sel_wdata = wdata[SIZE*i +: SIZE];
            end
        end
    end

    // Boundary inc/dec raise the flag whether the counter wraps or clamps.
    always_comb begin
        nxt_count = count;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (sel_op)
            OP_INC: begin
                if (count == ALL_ONES) begin
                    set_ovf   = 1'b1;
                    nxt_count = SAT ? ALL_ONES : '0;
                end else begin
                    nxt_count = count + SIZE'(1);
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    set_unf   = 1'b1;
                    nxt_count = SAT ? '0 : ALL_ONES;
                end else begin
                    nxt_count = count - SIZE'(1);
                end
            end
            OP_LOAD: nxt_count = sel_wdata;
            default: nxt_count = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= INIT_VAL;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            rsp_valid <= xfer;
            if (xfer) begin
                count     <= nxt_count;
                ptr       <= (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
                rsp_id    <= win_id;
                rsp_count <= nxt_count;
            end
            // A flag set in the same cycle as clr_flags takes precedence.
            ovf <= (xfer & set_ovf) | (ovf & ~clr_flags);
            unf <= (xfer & set_unf) | (unf & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: a wrapping (INIT=5) and a saturating (INIT=0)
// instance share one stimulus stream and are checked against a behavioural model.
module tb_counter_share_arbiter;

    localparam int NREQ = 4;
    localparam int SIZE = 8;
    localparam int NDUT = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [2*NREQ-1:0]    op = '0;
    logic [NREQ*SIZE-1:0] wdata = '0;
    logic                 clr_flags = 1'b0;

    logic [NREQ-1:0] gnt_a       [NDUT];
    logic [SIZE-1:0] count_a     [NDUT];
    logic            rsp_valid_a [NDUT];
    logic [1:0]      rsp_id_a    [NDUT];
    logic [SIZE-1:0] rsp_count_a [NDUT];
    logic            ovf_a       [NDUT];
    logic            unf_a       [NDUT];

    counter_share_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .INIT(5), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt_a[0]), .count(count_a[0]), .rsp_valid(rsp_valid_a[0]),
        .rsp_id(rsp_id_a[0]), .rsp_count(rsp_count_a[0]),
        .ovf(ovf_a[0]), .unf(unf_a[0]), .clr_flags(clr_flags)
    );

    counter_share_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .INIT(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt_a[1]), .count(count_a[1]), .rsp_valid(rsp_valid_a[1]),
        .rsp_id(rsp_id_a[1]), .rsp_count(rsp_count_a[1]),
        .ovf(ovf_a[1]), .unf(unf_a[1]), .clr_flags(clr_flags)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // reference model
    int n_cmp = 0;
    int n_bad = 0;
    int m_count [NDUT];
    int m_ptr   [NDUT];
    int m_rid   [NDUT];
    int m_rc    [NDUT];
    bit m_rv    [NDUT];
    bit m_ovf   [NDUT];
    bit m_unf   [NDUT];
    int wait_cnt [NREQ];
    int last_w = -1;

    function automatic int init_of(input int k);
        return (k == 0) ? 5 : 0;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1);
    endfunction

    function automatic int winner(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_count[k] = init_of(k);
            m_ptr[k]   = 0;
            m_rid[k]   = 0;
            m_rc[k]    = 0;
            m_rv[k]    = 1'b0;
            m_ovf[k]   = 1'b0;
            m_unf[k]   = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        last_w = -1;
    endtask

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            int w;
            int c;
            int opc;
            bit so;
            bit su;
            w  = winner(m_ptr[k], req);
            so = 1'b0;
            su = 1'b0;
            m_rv[k] = (w >= 0);
            if (w >= 0) begin
                c   = m_count[k];
                opc = int'(op[2*w +: 2]);
                case (opc)
                    0: if (c == 255) begin so = 1'b1; c = sat_of(k) ? 255 : 0; end else c = c + 1;
                    1: if (c == 0)   begin su = 1'b1; c = sat_of(k) ? 0 : 255; end else c = c - 1;
                    2: c = int'(wdata[8*w +: 8]);
                    default: c = c;
                endcase
                m_count[k] = c;
                m_rid[k]   = w;
                m_rc[k]    = c;
                m_ptr[k]   = (w + 1) % NREQ;
            end
            m_ovf[k] = so || (m_ovf[k] && !clr_flags);
            m_unf[k] = su || (m_unf[k] && !clr_flags);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("count%0d", k),     32'(count_a[k]),     32'(m_count[k]));
            check($sformatf("rsp_valid%0d", k), 32'(rsp_valid_a[k]), 32'(m_rv[k]));
            check($sformatf("rsp_id%0d", k),    32'(rsp_id_a[k]),    32'(m_rid[k]));
            check($sformatf("rsp_count%0d", k), 32'(rsp_count_a[k]), 32'(m_rc[k]));
            check($sformatf("ovf%0d", k),       32'(ovf_a[k]),       32'(m_ovf[k]));
            check($sformatf("unf%0d", k),       32'(unf_a[k]),       32'(m_unf[k]));
        end
    endtask

    // driver tasks: each cycle starts just after a rising edge with inputs set
    task automatic cycle();
        int w;
        #2;
        for (int k = 0; k < NDUT; k++) begin
            w = winner(m_ptr[k], req);
            check($sformatf("gnt%0d", k), 32'(gnt_a[k]), (w < 0) ? 32'd0 : (32'd1 << w));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !gnt_a[0][i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (req[i]) check($sformatf("starve%0d", i), 32'(wait_cnt[i] < NREQ), 32'd1);
        end
        last_w = winner(m_ptr[0], req);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic one_op(input int i, input logic [1:0] opc, input logic [7:0] data);
        req = '0;
        req[i] = 1'b1;
        op[2*i +: 2] = opc;
        wdata[8*i +: 8] = data;
        cycle();
        req = '0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && last_w != i) continue;
            req[i] = ($urandom_range(0, 99) < 60);
            op[2*i +: 2] = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: wdata[8*i +: 8] = 8'h00;
                1: wdata[8*i +: 8] = 8'hFF;
                2: wdata[8*i +: 8] = 8'hFE;
                3: wdata[8*i +: 8] = 8'h01;
                default: wdata[8*i +: 8] = 8'($urandom);
            endcase
        end
        clr_flags = ($urandom_range(0, 15) == 0);
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_gnt%0d", k), 32'(gnt_a[k]), 32'd0);
        end
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // main sequence
    initial begin
        model_reset();
        reset = 1'b1;
        req   = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", 32'(gnt_a[0]), 32'd0);
        check_outputs();
        reset = 1'b0;
        req   = '0;
        #1;
        check("init_count", 32'(count_a[0]), 32'd5);
        check("init_rsp_valid", 32'(rsp_valid_a[0]), 32'd0);
        check("init_gnt", 32'(gnt_a[0]), 32'd0);

        // single increment from requester 2
        req = 4'b0100;
        op  = '0;
        #1;
        check("t1_gnt", 32'(gnt_a[0]), 32'b0100);
        cycle();
        req = '0;
        check("t1_count", 32'(count_a[0]), 32'd6);
        check("t1_rsp_valid", 32'(rsp_valid_a[0]), 32'd1);
        check("t1_rsp_id", 32'(rsp_id_a[0]), 32'd2);
        check("t1_rsp_count", 32'(rsp_count_a[0]), 32'd6);

        // clear to 0 (pointer returns to 0), then round-robin increments
        one_op(3, 2'b10, 8'h00);
        req = '1;
        op  = '0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            check("t2_order", 32'(rsp_id_a[0]), 32'(c % NREQ));
        end
        req = '0;
        check("t2_count_wrap", 32'(count_a[0]), 32'd8);
        check("t2_count_sat", 32'(count_a[1]), 32'd8);

        // boundaries: wrap vs clamp
        one_op(0, 2'b10, 8'hFF);
        one_op(1, 2'b00, 8'h00);
        check("inc_wrap_count", 32'(count_a[0]), 32'h00);
        check("inc_wrap_ovf", 32'(ovf_a[0]), 32'd1);
        check("inc_sat_count", 32'(count_a[1]), 32'hFF);
        check("inc_sat_ovf", 32'(ovf_a[1]), 32'd1);
        one_op(2, 2'b10, 8'h00);
        one_op(3, 2'b01, 8'h00);
        check("dec_wrap_count", 32'(count_a[0]), 32'hFF);
        check("dec_wrap_unf", 32'(unf_a[0]), 32'd1);
        check("dec_sat_count", 32'(count_a[1]), 32'h00);
        check("dec_sat_unf", 32'(unf_a[1]), 32'd1);
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        check("clr_ovf", 32'(ovf_a[0]), 32'd0);
        check("clr_unf", 32'(unf_a[1]), 32'd0);
        one_op(0, 2'b10, 8'hFF);
        clr_flags = 1'b1;
        one_op(1, 2'b00, 8'h00);
        clr_flags = 1'b0;
        check("set_beats_clr0", 32'(ovf_a[0]), 32'd1);
        check("set_beats_clr1", 32'(ovf_a[1]), 32'd1);

        // load and read contending with pointer at 0
        one_op(3, 2'b11, 8'h00);
        req = 4'b1010;
        op[3:2] = 2'b10;
        wdata[15:8] = 8'h3C;
        op[7:6] = 2'b11;
        cycle();
        check("t5_first_id", 32'(rsp_id_a[0]), 32'd1);
        check("t5_first_count", 32'(count_a[0]), 32'h3C);
        req[1] = 1'b0;
        cycle();
        check("t5_second_id", 32'(rsp_id_a[0]), 32'd3);
        check("t5_second_count", 32'(rsp_count_a[0]), 32'h3C);
        req = '0;

        // asynchronous reset in the middle of a busy stream
        req = '1;
        for (int i = 0; i < NREQ; i++) op[2*i +: 2] = 2'($urandom_range(0, 3));
        repeat (3) cycle();
        async_reset();
        check("t6_count", 32'(count_a[0]), 32'd5);
        check("t6_rsp_valid", 32'(rsp_valid_a[0]), 32'd0);
        #1;
        check("t6_first_gnt", 32'(gnt_a[0]), 32'b0001);
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            if ($urandom_range(0, 399) == 0) async_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
